// File: rtl/chao_pkg.sv
// Shared types and defaults for the ultrasonic ranging front-end.
package chao_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  localparam int DIST_W        = 10;
  localparam int MAX_CM_DEF    = 1023;
  localparam int US_PER_CM_DEF = 58;

  // Bits needed to hold any value 0..maxval.
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/chao_echo_ranger_if.sv
// Sensor pins and result bus of the echo ranger; master is the ranger side.
interface chao_echo_ranger_if;
  import chao_pkg::*;

  logic              echo;
  logic              trig;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              timeout;
  logic              busy;

  modport master (
    input  echo,
    output trig, dist_cm, dist_valid, timeout, busy
  );

  modport slave (
    output echo,
    input  trig, dist_cm, dist_valid, timeout, busy
  );

endinterface

// File: rtl/chao_us_tick.sv
// Prescaler: one-cycle tick every DIV clocks, phase counted from reset release.
module chao_us_tick #(
  parameter int DIV = 100
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/chao_echo_ranger.sv
// Periodic trigger generator and echo-width timer producing whole-centimetre results.
// Define CHAO_ECHO_DEGLITCH_EN to insert a 4-sample stability filter on the echo input.
module chao_echo_ranger
  import chao_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = US_PER_CM_DEF,
  parameter int MAX_CM     = MAX_CM_DEF
) (
  input  logic               Clock,
  input  logic               Reset_n,
  chao_echo_ranger_if.master bus
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = cnt_w(PERIOD_US);
  localparam int TW  = cnt_w(TIMEOUT_US);
  localparam int GW  = cnt_w(TRIG_US);
  localparam int SW  = cnt_w(US_PER_CM);

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v >= DIST_W'(MAX_CM)) ? DIST_W'(MAX_CM) : v + DIST_W'(1);
  endfunction

  logic              tick;
  logic              echo_p0, echo_p1;
  logic              lvl, lvl_p2;
  logic              rise, fall;

  state_t            state, state_n;
  logic              first_trig;
  logic [PW-1:0]     period_cnt;
  logic [GW-1:0]     trig_cnt;
  logic [TW-1:0]     wait_cnt;
  logic [SW-1:0]     sub_cnt, sub_n;
  logic [DIST_W-1:0] cm_cnt, cm_n;
  logic [DIST_W-1:0] dist_q;
  logic              timeout_q, valid_q;
  logic              good_evt, to_evt;
  logic              period_hit, wait_last;

  chao_us_tick #(.DIV(DIV)) u_tick (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .tick    (tick)
  );

  // Stage p0/p1: two-flop synchroniser for the asynchronous echo pin
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      echo_p0 <= 1'b0;
      echo_p1 <= 1'b0;
    end else begin
      echo_p0 <= bus.echo;
      echo_p1 <= echo_p0;
    end
  end

`ifdef CHAO_ECHO_DEGLITCH_EN
  logic [2:0] hist;
  logic       filt;

  // Level moves only once the current sample and the three before it agree
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[1:0], echo_p1};
      if ((hist == {3{echo_p1}}) && (filt != echo_p1)) begin
        filt <= echo_p1;
      end
    end
  end

  assign lvl = filt;
`else
  assign lvl = echo_p1;
`endif

  // Stage p2: previous level for edge detection
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      lvl_p2 <= 1'b0;
    end else begin
      lvl_p2 <= lvl;
    end
  end

  assign rise = lvl & ~lvl_p2;
  assign fall = ~lvl & lvl_p2;

  assign period_hit = (period_cnt >= PW'(PERIOD_US - 1));
  assign wait_last  = (wait_cnt == TW'(TIMEOUT_US - 1));

  // Distance counters including this cycle's tick, so a fall on a tick sees it counted
  always_comb begin
    sub_n = sub_cnt;
    cm_n  = cm_cnt;
    if (tick) begin
      if (sub_cnt == SW'(US_PER_CM - 1)) begin
        sub_n = '0;
        cm_n  = sat_inc(cm_cnt);
      end else begin
        sub_n = sub_cnt + SW'(1);
      end
    end
  end

  always_comb begin
    state_n  = state;
    good_evt = 1'b0;
    to_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (tick && (first_trig || period_hit)) begin
          state_n = TRIG;
        end
      end
      TRIG: begin
        if (tick && (trig_cnt == GW'(TRIG_US - 1))) begin
          state_n = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (tick && wait_last) begin
          to_evt  = 1'b1;
          state_n = IDLE;
        end else if (rise) begin
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        if (fall) begin
          good_evt = 1'b1;
          state_n  = IDLE;
        end else if (tick && wait_last) begin
          to_evt  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      first_trig <= 1'b1;
      period_cnt <= '0;
      trig_cnt   <= '0;
    end else if ((state == IDLE) && (state_n == TRIG)) begin
      first_trig <= 1'b0;
      period_cnt <= '0;
      trig_cnt   <= '0;
    end else if (tick) begin
      // Saturating period timer keeps a late trigger pending rather than lost
      if (period_cnt < PW'(PERIOD_US)) begin
        period_cnt <= period_cnt + PW'(1);
      end
      if (state == TRIG) begin
        trig_cnt <= trig_cnt + GW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
    end else if ((state == TRIG) && (state_n == WAIT_RISE)) begin
      wait_cnt <= '0;
    end else if ((state == WAIT_RISE) && (state_n == MEASURE)) begin
      wait_cnt <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
    end else begin
      if (tick && ((state == WAIT_RISE) || (state == MEASURE))) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (state == MEASURE) begin
        sub_cnt <= sub_n;
        cm_cnt  <= cm_n;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      dist_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= good_evt | to_evt;
      if (good_evt) begin
        dist_q    <= cm_n;
        timeout_q <= 1'b0;
      end else if (to_evt) begin
        dist_q    <= DIST_W'(MAX_CM);
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.trig       = (state == TRIG);
  assign bus.busy       = (state != IDLE);
  assign bus.dist_cm    = dist_q;
  assign bus.dist_valid = valid_q;
  assign bus.timeout    = timeout_q;

endmodule
